mem_req_arbiter: RTL and testbench

- Shares the single memory-request port of the AXI memory interface unit between three requesters: instruction fetch, load/store (mem) and the page-table walker (ptw).
- Uses the same pulse-style request/response protocol on both sides.
- Latches one pending request per requester and grants the bus round-robin, with one transaction outstanding at a time.
- Sits between the core front/back-end and the memory interface unit. Also provides a response timeout so a hung backend cannot deadlock the core.

---
 rtl/mem_req_arbiter_if.sv | 34 +++
 rtl/mem_req_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter_if
// Request/response bus between the arbiter and the memory interface unit.
// The arbiter drives requests and the memory interface unit drives responses.
// Both directions use one-cycle enable pulses.
//
// Signals:
//   bus_request_enable  : one-cycle request pulse (master -> slave)
//   breq_mode           : MEMREQ_READ / MEMREQ_WRITE
//   breq_addr           : 32-bit address
//   breq_wdata          : 32-bit write data
//   breq_wstrb          : 4-bit byte strobes
//   bus_response_enable : one-cycle response pulse (slave -> master)
//   bresp_data          : 32-bit response data
// ---------------------------------------------------------------------------
interface mem_req_arbiter_if;
  logic        bus_request_enable;
  logic        breq_mode;
  logic [31:0] breq_addr;
  logic [31:0] breq_wdata;
  logic [3:0]  breq_wstrb;
  logic        bus_response_enable;
  logic [31:0] bresp_data;

  modport master (
    output bus_request_enable, breq_mode, breq_addr, breq_wdata, breq_wstrb,
    input  bus_response_enable, bresp_data
  );

  modport slave (
    input  bus_request_enable, breq_mode, breq_addr, breq_wdata, breq_wstrb,
    output bus_response_enable, bresp_data
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
// Shares the single memory-request port between three requesters: fetch (0),
// load/store mem (1) and page-table walker ptw (2). Each requester's pulse
// is latched into its own slot. The bus is granted round-robin, with one
// transaction outstanding at a time. If the backend stays silent for TIMEOUT
// cycles, an error response is returned. The arbiter then drains the late
// backend response, so the backend stays in step with the arbiter.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   *_request_enable, *req_* : per-requester request pulse and fields
//   *_response_enable, *resp_data : per-requester response pulse and data
//   resp_error               : qualifies a response pulse; 1 = timed out
//   bus (master modport)     : request/response port to the memory unit
//   grant_id                 : current or last granted requester
//   overflow                 : sticky; a pulse arrived while that requester
//                              was already pending
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_request_enable,
  input  logic                  freq_mode,
  input  logic [31:0]           freq_addr,
  input  logic [31:0]           freq_wdata,
  input  logic [3:0]            freq_wstrb,
  output logic                  fetch_response_enable,
  output logic [31:0]           fresp_data,
  input  logic                  mem_request_enable,
  input  logic                  mreq_mode,
  input  logic [31:0]           mreq_addr,
  input  logic [31:0]           mreq_wdata,
  input  logic [3:0]            mreq_wstrb,
  output logic                  mem_response_enable,
  output logic [31:0]           mresp_data,
  input  logic                  ptw_request_enable,
  input  logic                  preq_mode,
  input  logic [31:0]           preq_addr,
  input  logic [31:0]           preq_wdata,
  input  logic [3:0]            preq_wstrb,
  output logic                  ptw_response_enable,
  output logic [31:0]           presp_data,
  output logic                  resp_error,
  mem_req_arbiter_if.master     bus,
  output logic [1:0]            grant_id,
  output logic                  overflow
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  localparam bit          C_TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] C_TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  logic [2:0]        w_req_pulse;
  logic [2:0]        w_req_mode;
  logic [2:0][31:0]  w_req_addr, w_req_wdata;
  logic [2:0][3:0]   w_req_wstrb;

  logic [2:0]        r_slot_mode;
  logic [2:0][31:0]  r_slot_addr, r_slot_wdata;
  logic [2:0][3:0]   r_slot_wstrb;

  logic [1:0]        r_state;
  logic [2:0]        r_pending;
  logic [15:0]       r_count;
  logic [1:0]        r_grant_id;
  logic              r_overflow;
  logic [2:0]        r_resp_en;
  logic [2:0][31:0]  r_resp_data;
  logic              r_resp_error;
  logic              r_bus_req;
  logic              r_breq_mode;
  logic [31:0]       r_breq_addr, r_breq_wdata;
  logic [3:0]        r_breq_wstrb;

  logic              w_any;
  logic [1:0]        w_winner;
  logic              w_sel_mode;
  logic [31:0]       w_sel_addr, w_sel_wdata;
  logic [3:0]        w_sel_wstrb;

  assign w_req_pulse = {ptw_request_enable, mem_request_enable, fetch_request_enable};
  assign w_req_mode  = {preq_mode, mreq_mode, freq_mode};
  assign w_req_addr  = {preq_addr, mreq_addr, freq_addr};
  assign w_req_wdata = {preq_wdata, mreq_wdata, freq_wdata};
  assign w_req_wstrb = {preq_wstrb, mreq_wstrb, freq_wstrb};

  // Round-robin pick from grant_id+1. The search runs from farthest to
  // nearest, so the nearest pending requester is the last one assigned.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
    w_any    = |r_pending;
    w_winner = r_grant_id;
    for (int k = 3; k >= 1; k--) begin
      int idx;
      idx = int'(r_grant_id) + k;
      if (idx >= 3) idx = idx - 3;
      if (r_pending[idx]) w_winner = 2'(idx);
    end
    w_sel_mode  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_winner == 2'(i)) begin
        w_sel_mode  = r_slot_mode[i];
        w_sel_addr  = r_slot_addr[i];
        w_sel_wdata = r_slot_wdata[i];
        w_sel_wstrb = r_slot_wstrb[i];
      end
    end
  end

  // Request slots capture on acceptance only. While a requester is pending,
  // its slot is frozen.
  // NOTE: slot storage has no reset; a slot is never read unless its pending bit, which is reset, is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_req_pulse[i] && !r_pending[i]) begin
        r_slot_mode[i]  <= w_req_mode[i];
        r_slot_addr[i]  <= w_req_addr[i];
        r_slot_wdata[i] <= w_req_wdata[i];
        r_slot_wstrb[i] <= w_req_wstrb[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_count      <= '0;
      r_grant_id   <= 2'd2;
      r_overflow   <= 1'b0;
      r_resp_en    <= '0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
      r_bus_req    <= 1'b0;
      r_breq_mode  <= 1'b0;
      r_breq_addr  <= '0;
      r_breq_wdata <= '0;
      r_breq_wstrb <= '0;
    end else begin
      // Acceptance sets a pending bit only when it is clear. Completion clears
      // a bit only when it is set. The two therefore never meet on one bit.
      for (int i = 0; i < 3; i++) begin
        if (w_req_pulse[i]) begin
          if (r_pending[i]) r_overflow <= 1'b1;
          else              r_pending[i] <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id   <= w_winner;
            r_breq_mode  <= w_sel_mode;
            r_breq_addr  <= w_sel_addr;
            r_breq_wdata <= w_sel_wdata;
            r_breq_wstrb <= w_sel_wstrb;
            r_bus_req    <= 1'b1;
            r_count      <= '0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_bus_req <= 1'b0;
          if (bus.bus_response_enable) begin
            for (int i = 0; i < 3; i++) begin
              if (r_grant_id == 2'(i)) begin
                r_resp_en[i]   <= 1'b1;
                r_resp_data[i] <= bus.bresp_data;
                r_pending[i]   <= 1'b0;
              end
            end
            r_resp_error <= 1'b0;
            r_state      <= S_RESPOND;
          end else if (C_TO_EN && r_count == C_TO_LAST) begin
            for (int i = 0; i < 3; i++) begin
              if (r_grant_id == 2'(i)) begin
                r_resp_en[i]   <= 1'b1;
                r_resp_data[i] <= '0;
                r_pending[i]   <= 1'b0;
              end
            end
            r_resp_error <= 1'b1;
            r_state      <= S_DRAIN;
          end else begin
            r_count <= r_count + 16'd1;
          end
        end
        S_RESPOND: begin
          r_resp_en    <= '0;
          r_resp_error <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin  // S_DRAIN: swallow the late backend response
          r_resp_en    <= '0;
          r_resp_error <= 1'b0;
          if (bus.bus_response_enable) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fetch_response_enable  = r_resp_en[0];
  assign mem_response_enable    = r_resp_en[1];
  assign ptw_response_enable    = r_resp_en[2];
  assign fresp_data             = r_resp_data[0];
  assign mresp_data             = r_resp_data[1];
  assign presp_data             = r_resp_data[2];
  assign resp_error             = r_resp_error;
  assign grant_id               = r_grant_id;
  assign overflow               = r_overflow;
  assign bus.bus_request_enable = r_bus_req;
  assign bus.breq_mode          = r_breq_mode;
  assign bus.breq_addr          = r_breq_addr;
  assign bus.breq_wdata         = r_breq_wdata;
  assign bus.breq_wstrb         = r_breq_wstrb;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
// Self-checking bench for mem_req_arbiter, with TIMEOUT=8. A table of single
// transactions is followed by hand-written sequences: round-robin ordering,
// overflow, timeout with drain, and reset mid-transaction. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        fetch_request_enable, freq_mode;
  logic [31:0] freq_addr, freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable;
  logic [31:0] fresp_data;
  logic        mem_request_enable, mreq_mode;
  logic [31:0] mreq_addr, mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable;
  logic [31:0] mresp_data;
  logic        ptw_request_enable, preq_mode;
  logic [31:0] preq_addr, preq_wdata;
  logic [3:0]  preq_wstrb;
  logic        ptw_response_enable;
  logic [31:0] presp_data;
  logic        resp_error;
  logic [1:0]  grant_id;
  logic        overflow;

  mem_req_arbiter_if bus_if ();

  mem_req_arbiter #(.TIMEOUT(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .fetch_request_enable  (fetch_request_enable),
    .freq_mode             (freq_mode),
    .freq_addr             (freq_addr),
    .freq_wdata            (freq_wdata),
    .freq_wstrb            (freq_wstrb),
    .fetch_response_enable (fetch_response_enable),
    .fresp_data            (fresp_data),
    .mem_request_enable    (mem_request_enable),
    .mreq_mode             (mreq_mode),
    .mreq_addr             (mreq_addr),
    .mreq_wdata            (mreq_wdata),
    .mreq_wstrb            (mreq_wstrb),
    .mem_response_enable   (mem_response_enable),
    .mresp_data            (mresp_data),
    .ptw_request_enable    (ptw_request_enable),
    .preq_mode             (preq_mode),
    .preq_addr             (preq_addr),
    .preq_wdata            (preq_wdata),
    .preq_wstrb            (preq_wstrb),
    .ptw_response_enable   (ptw_response_enable),
    .presp_data            (presp_data),
    .resp_error            (resp_error),
    .bus                   (bus_if),
    .grant_id              (grant_id),
    .overflow              (overflow)
  );

  typedef struct {
    int          id;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [5];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic m, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s);
    case (id)
      0: begin fetch_request_enable = 1'b1; freq_mode = m; freq_addr = a; freq_wdata = w; freq_wstrb = s; end
      1: begin mem_request_enable   = 1'b1; mreq_mode = m; mreq_addr = a; mreq_wdata = w; mreq_wstrb = s; end
      default: begin ptw_request_enable = 1'b1; preq_mode = m; preq_addr = a; preq_wdata = w; preq_wstrb = s; end
    endcase
  endtask

  // Request fields are junk outside the pulse cycle, so a late capture shows up.
  task automatic clear_reqs();
    fetch_request_enable = 1'b0; mem_request_enable = 1'b0; ptw_request_enable = 1'b0;
    freq_mode = 1'b1; freq_addr = 32'hBAD0_0BAD; freq_wdata = 32'hFFFF_0000; freq_wstrb = 4'hF;
    mreq_mode = 1'b1; mreq_addr = 32'hBAD1_1BAD; mreq_wdata = 32'hFFFF_1111; mreq_wstrb = 4'hF;
    preq_mode = 1'b1; preq_addr = 32'hBAD2_2BAD; preq_wdata = 32'hFFFF_2222; preq_wstrb = 4'hF;
  endtask

  task automatic respond(input logic [31:0] d);
    bus_if.bus_response_enable = 1'b1;
    bus_if.bresp_data          = d;
    step();
    bus_if.bus_response_enable = 1'b0;
    bus_if.bresp_data          = 32'h0BAD_F00D;
  endtask

  function automatic logic [31:0] all_en();
    return {29'd0, ptw_response_enable, mem_response_enable, fetch_response_enable};
  endfunction

  function automatic logic [31:0] resp_dat(input int id);
    case (id)
      0:       return fresp_data;
      1:       return mresp_data;
      default: return presp_data;
    endcase
  endfunction

  // Wait (bounded) for the grant, check the issued fields, return the backend
  // response 'lat' edges after the grant edge, and check the response pulse.
  task automatic serve(input string tag, input int id, input logic m, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] s, input int lat,
                       input logic [31:0] rd, output int waited);
    waited = 0;
    while (bus_if.bus_request_enable !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    check({tag, "/bus_req"}, 32'(bus_if.bus_request_enable), 32'd1);
    check({tag, "/grant_id"}, 32'(grant_id), 32'(id));
    check({tag, "/mode"},  32'(bus_if.breq_mode), 32'(m));
    check({tag, "/addr"},  bus_if.breq_addr, a);
    check({tag, "/wdata"}, bus_if.breq_wdata, w);
    check({tag, "/wstrb"}, 32'(bus_if.breq_wstrb), 32'(s));
    for (int k = 1; k < lat; k++) begin
      step();
      if (k == 1) check({tag, "/bus_req_pulse"}, 32'(bus_if.bus_request_enable), 32'd0);
    end
    respond(rd);
    check({tag, "/resp_en"},  all_en(), 32'd1 << id);
    check({tag, "/resp_dat"}, resp_dat(id), rd);
    check({tag, "/resp_err"}, 32'(resp_error), 32'd0);
    step();
    check({tag, "/resp_off"}, all_en(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int waited;
    int n;
    int seen;

    vecs[0] = '{0, 1'b0, 32'h0000_1000, 32'h0000_0000, 4'h0,    5, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 32'h0000_2004, 32'h55AA_00FF, 4'b0011, 3, 32'h0000_0001};
    vecs[2] = '{2, 1'b0, 32'h0000_3000, 32'h0000_0000, 4'h0,    2, 32'h1234_5678};
    vecs[3] = '{0, 1'b1, 32'h0000_1FFC, 32'hA5A5_5A5A, 4'hF,    4, 32'h0000_0000};
    vecs[4] = '{2, 1'b0, 32'h0000_3008, 32'h0000_0000, 4'h0,    2, 32'hCAFE_F00D};

    rst = 1'b1;
    clear_reqs();
    bus_if.bus_response_enable = 1'b0;
    bus_if.bresp_data          = 32'h0;
    repeat (3) step();
    rst = 1'b0;

    check("rst/bus_req",  32'(bus_if.bus_request_enable), 32'd0);
    check("rst/breq_addr", bus_if.breq_addr, 32'd0);
    check("rst/grant_id", 32'(grant_id), 32'd2);
    check("rst/resp_en",  all_en(), 32'd0);
    check("rst/resp_err", 32'(resp_error), 32'd0);
    check("rst/overflow", 32'(overflow), 32'd0);
    check("rst/fresp",    fresp_data, 32'd0);

    // Single transactions from the table.
    for (int i = 0; i < 5; i++) begin
      set_req(vecs[i].id, vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      step();
      clear_reqs();
      check($sformatf("v%0d/no_same_edge_grant", i), 32'(bus_if.bus_request_enable), 32'd0);
      serve($sformatf("v%0d", i), vecs[i].id, vecs[i].mode, vecs[i].addr, vecs[i].wdata,
            vecs[i].wstrb, vecs[i].lat, vecs[i].rdata, waited);
      check($sformatf("v%0d/grant_latency", i), 32'(waited), 32'd1);
    end
    check("vec/overflow", 32'(overflow), 32'd0);

    // Three simultaneous requests after last=ptw: order fetch, mem, ptw.
    set_req(0, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h0000_5000, 32'h1111_2222, 4'b1100);
    set_req(2, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
    step();
    clear_reqs();
    serve("rr0", 0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 2, 32'hA000_0001, waited);
    serve("rr1", 1, 1'b1, 32'h0000_5000, 32'h1111_2222, 4'b1100, 2, 32'hA000_0002, waited);
    check("rr1/turnaround", 32'(waited), 32'd1);
    serve("rr2", 2, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 2, 32'hA000_0003, waited);
    check("rr2/turnaround", 32'(waited), 32'd1);

    // Last=ptw, so mem+fetch goes fetch first.
    set_req(1, 1'b0, 32'h0000_5100, 32'h0, 4'h0);
    set_req(0, 1'b0, 32'h0000_4100, 32'h0, 4'h0);
    step();
    clear_reqs();
    serve("rr3", 0, 1'b0, 32'h0000_4100, 32'h0, 4'h0, 2, 32'hA000_0004, waited);
    serve("rr4", 1, 1'b0, 32'h0000_5100, 32'h0, 4'h0, 2, 32'hA000_0005, waited);

    // Last=mem, so fetch+ptw goes ptw first.
    set_req(0, 1'b0, 32'h0000_4200, 32'h0, 4'h0);
    set_req(2, 1'b0, 32'h0000_6200, 32'h0, 4'h0);
    step();
    clear_reqs();
    serve("rr5", 2, 1'b0, 32'h0000_6200, 32'h0, 4'h0, 2, 32'hA000_0006, waited);
    serve("rr6", 0, 1'b0, 32'h0000_4200, 32'h0, 4'h0, 2, 32'hA000_0007, waited);

    // Second mem pulse while the first is in flight.
    set_req(1, 1'b1, 32'h0000_7000, 32'h0000_FACE, 4'hC);
    step();
    clear_reqs();
    step();
    check("ovf/bus_req", 32'(bus_if.bus_request_enable), 32'd1);
    check("ovf/addr",    bus_if.breq_addr, 32'h0000_7000);
    set_req(1, 1'b0, 32'h0000_7777, 32'h0, 4'h0);
    step();
    clear_reqs();
    check("ovf/flag", 32'(overflow), 32'd1);
    respond(32'h7000_0001);
    check("ovf/resp_en",  all_en(), 32'd2);
    check("ovf/resp_dat", mresp_data, 32'h7000_0001);
    seen = 0;
    repeat (6) begin
      step();
      if (bus_if.bus_request_enable === 1'b1) seen++;
    end
    check("ovf/single_txn", 32'(seen), 32'd0);
    check("ovf/sticky", 32'(overflow), 32'd1);

    // Timeout with a silent backend; ptw queued behind it waits out the drain.
    set_req(1, 1'b0, 32'h0000_8000, 32'h0, 4'h0);
    step();
    clear_reqs();
    step();
    check("to/bus_req", 32'(bus_if.bus_request_enable), 32'd1);
    check("to/grant",   32'(grant_id), 32'd1);
    set_req(2, 1'b0, 32'h0000_9000, 32'h0, 4'h0);
    step();
    clear_reqs();
    n = 1;
    while (mem_response_enable !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("to/cycles",   32'(n), 32'd8);
    check("to/resp_en",  all_en(), 32'd2);
    check("to/resp_dat", mresp_data, 32'd0);
    check("to/resp_err", 32'(resp_error), 32'd1);
    step();
    check("to/resp_off", all_en(), 32'd0);
    check("to/err_off",  32'(resp_error), 32'd0);
    seen = 0;
    repeat (4) begin
      step();
      if (bus_if.bus_request_enable === 1'b1) seen++;
    end
    check("to/drain_hold", 32'(seen), 32'd0);
    respond(32'h5555_5555);
    check("to/late_discard", all_en(), 32'd0);
    serve("to_ptw", 2, 1'b0, 32'h0000_9000, 32'h0, 4'h0, 2, 32'h9999_0000, waited);
    check("to_ptw/after_drain", 32'(waited), 32'd1);

    // Reset in the middle of a transaction.
    set_req(0, 1'b0, 32'h0000_A000, 32'h0, 4'h0);
    step();
    clear_reqs();
    step();
    check("rst2/bus_req_pre", 32'(bus_if.bus_request_enable), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2/bus_req",  32'(bus_if.bus_request_enable), 32'd0);
    check("rst2/addr",     bus_if.breq_addr, 32'd0);
    check("rst2/grant_id", 32'(grant_id), 32'd2);
    check("rst2/overflow", 32'(overflow), 32'd0);
    check("rst2/fresp",    fresp_data, 32'd0);
    check("rst2/presp",    presp_data, 32'd0);
    respond(32'hDEAD_0000);
    check("rst2/stray_resp", all_en(), 32'd0);
    step();
    check("rst2/no_reissue", 32'(bus_if.bus_request_enable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
